stack_arbiter: RTL
==================

// Module: stack_arbiter
// PURPOSE
//  Shares one stack instance (push/pop/data_in/data_out/full/empty) among NREQ requesters.
//  - Arbitrates requests, issues exactly one stack operation at a time, returns pop data.
//  - Blocks push-on-full and pop-on-empty; these return an error response.
//  - Sits between client blocks and the stack. It is the only driver of the stack's push, pop and data_in.
// PARAMETERS
//  WIDTH  8  data width; must match the stack's WIDTH
//  NREQ   4  number of requesters (>=2)
// PORTS
//  clk          in   1           single clock, all logic on posedge
//  rst_n        in   1           asynchronous, active-low reset
//  req          in   NREQ        per-requester request; held until gnt[i] is seen
//  op           in   NREQ        per-requester op: 0=push, 1=pop; stable while req[i]=1
//  wdata        in   NREQ*WIDTH  push data; requester i uses bits [i*WIDTH +: WIDTH]
//  gnt          out  NREQ        one-hot, 1-cycle pulse: request accepted
//  rsp_valid    out  NREQ        one-hot, 1-cycle pulse: operation complete
//  rsp_data     out  WIDTH       popped value, valid with rsp_valid; 0 for push or error
//  rsp_err      out  1           valid with rsp_valid: op rejected (full/empty)
//  stk_push     out  1           to stack push
//  stk_pop      out  1           to stack pop
//  stk_data_in  out  WIDTH       to stack data_in
//  stk_data_out in   WIDTH       from stack; holds the popped value one cycle after the pop edge
//  stk_full     in   1           from stack
//  stk_empty    in   1           from stack
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - All outputs 0; state=IDLE.
//    - RR pointer last=NREQ-1, so requester 0 wins first.
//    - In-flight op is abandoned with no response.
//    - A stack op already sampled by the stack is not undone.
//  - All outputs are registered.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE, at an edge with |req:
//    - Pick winner w: first set req after last, wrapping. last<=w; latch w, op[w], wdata[w]; gnt[w]<=1.
//    - Error case (op=0&stk_full, or op=1&stk_empty): rsp_valid[w]<=1, rsp_err<=1, rsp_data<=0.
//      No stk_push/stk_pop. Next state RESP.
//    - Otherwise: stk_push<=~op or stk_pop<=op, stk_data_in<=wdata[w]; next state ISSUE.
//  - ISSUE: gnt and the stk_* strobe are high for exactly this cycle.
//    - Edge out of ISSUE clears them.
//    - Push: rsp_valid[w]<=1, rsp_data<=0, rsp_err<=0; next state RESP.
//    - Pop: next state WAIT.
//  - WAIT: at the edge, rsp_data<=stk_data_out, rsp_valid[w]<=1, rsp_err<=0; next state RESP.
//  - RESP: rsp_valid (and gnt on error) high this cycle only; next state IDLE.
//    - rsp_data/rsp_err hold until the next response.
//  - Latency, acceptance edge to rsp_valid edge: push 2, pop 3, error 1 cycle(s).
//    - Next acceptance is possible at the edge after RESP.
//  - req is ignored outside IDLE. Requester must drop or refresh req at the edge after seeing gnt.
//  - stk_full/stk_empty are sampled only in IDLE. They are stable because no stack op is pending then.
//  - stk_push and stk_pop are never both 1. At most one stack op is in flight.
// CONFIGURATION
//  STACK_ARB_FIXED_PRIO_EN defined:
//    - Fixed priority: lowest-index set req always wins; RR pointer is not used.
//  Undefined (default):
//    - Round-robin as above; no requester starves.
// TESTING
//  1. Reset: rst_n=0 mid-run -> all outputs 0 same cycle. After release, simultaneous req=4'b1111 -> gnt=4'b0001 first.
//  2. req[0] push 8'd10 -> gnt[0] and stk_push 1 cycle with stk_data_in=10. rsp_valid[0] 2 cycles after acceptance, rsp_err=0.
//  3. req[1] pushes 10, then 20; req[2] pops -> rsp_valid[2] 3 cycles after acceptance, rsp_data=20. Next pop -> 10.
//  4. req=4'b1111, all pushing, held -> grant order 0,1,2,3,0 (fixed-prio build: 0,0,...). stk_push never overlaps stk_pop.
//  5. Pop on empty stack -> gnt+rsp_valid at the same time, rsp_err=1, rsp_data=0, no stk_pop.
//     Push with stk_full=1 -> rsp_err=1, no stk_push.
//  6. rst_n=0 during WAIT of a pop -> no rsp_valid ever for that op. FSM idle; next request serviced normally.

Source files
------------

// File: rtl/stack_arbiter.sv
// Arbitrates NREQ requesters onto a single shared stack, one push or pop at a time.
// Define STACK_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module stack_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH-1:0]      stk_data_in,
  input  logic [WIDTH-1:0]      stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   cur;
  logic            cur_op;
  logic [IW-1:0]   win;
  logic            win_err;
  logic [WIDTH-1:0] win_data;

`ifdef STACK_ARB_FIXED_PRIO_EN
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r);
    logic [IW-1:0] sel;
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[IW'(i)]) sel = IW'(i);
    end
    return sel;
  endfunction

  always_comb begin
    win = pick(req);
  end
`else
  logic [IW-1:0] last;

  // Scan downward so the requester closest after 'last' is the final (winning) assignment.
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] l);
    logic [IW-1:0] sel;
    int            j;
    sel = '0;
    for (int d = NREQ; d >= 1; d--) begin
      j = (int'(l) + d) % NREQ;
      if (r[IW'(j)]) sel = IW'(j);
    end
    return sel;
  endfunction

  always_comb begin
    win = pick(req, last);
  end
`endif

  always_comb begin
    win_err  = op[win] ? stk_empty : stk_full;
    win_data = wdata[int'(win)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
`ifndef STACK_ARB_FIXED_PRIO_EN
      last        <= IW'(NREQ - 1);
`endif
      cur         <= '0;
      cur_op      <= 1'b0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
`ifndef STACK_ARB_FIXED_PRIO_EN
            last <= win;
`endif
            cur      <= win;
            cur_op   <= op[win];
            gnt[win] <= 1'b1;
            // Full/empty are stable here because no stack op is outstanding.
            if (win_err) begin
              rsp_valid[win] <= 1'b1;
              rsp_err        <= 1'b1;
              rsp_data       <= '0;
              state          <= RESP;
            end else begin
              stk_push    <= ~op[win];
              stk_pop     <= op[win];
              stk_data_in <= win_data;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          gnt      <= '0;
          stk_push <= 1'b0;
          stk_pop  <= 1'b0;
          if (cur_op) begin
            state <= WAIT;
          end else begin
            rsp_valid[cur] <= 1'b1;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            state          <= RESP;
          end
        end
        WAIT: begin
          rsp_valid[cur] <= 1'b1;
          rsp_data       <= stk_data_out;
          rsp_err        <= 1'b0;
          state          <= RESP;
        end
        RESP: begin
          gnt       <= '0;
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_one_op: assert property (@(posedge clk) disable iff (!rst_n) !(stk_push && stk_pop));
  a_gnt_oh: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_rsp_oh: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));

endmodule
